// File: rtl/classifier_pkg.sv
// Shared types for the classifier frame packer slice.
// Configuration macro used by the packer: CLASSIFIER_FRAME_PACKER_PINGPONG_EN.
package classifier_pkg;

    localparam int unsigned BIT_WIDTH_DEF = 32;
    localparam int unsigned N_SAMPLES_DEF = 8;

    // Per-frame FSM encoding; also reused as the per-buffer full/empty flag.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [BIT_WIDTH_DEF-1:0] sample_t;
    typedef sample_t frame_t [N_SAMPLES_DEF-1:0];

    // Index width for an n-entry frame; n >= 2 keeps this at least 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/classifier_frame_packer_if.sv
// Serial-in / frame-out handshake bundle for classifier_frame_packer.
// master = producer of samples and consumer of frames; slave = the packer.
interface classifier_frame_packer_if
    import classifier_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
);
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 send_val;
    logic                 send_rdy;
    logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0];

    modport master (
        output recv_val,
        output recv_msg,
        output send_rdy,
        input  recv_rdy,
        input  send_val,
        input  send_msg
    );

    modport slave (
        input  recv_val,
        input  recv_msg,
        input  send_rdy,
        output recv_rdy,
        output send_val,
        output send_msg
    );
endinterface

// File: rtl/classifier_frame_buf.sv
// N-entry write-indexed sample register array with async active-low clear.
module classifier_frame_buf
    import classifier_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned IDX_W     = idx_width(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] data [N_SAMPLES-1:0]
);

    // Write the addressed entry; all entries clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                if (we && (waddr == IDX_W'(k))) begin
                    data[k] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/classifier_frame_packer.sv
// Packs N_SAMPLES serial samples into one frame for the classifier array port.
// Optional macro CLASSIFIER_FRAME_PACKER_PINGPONG_EN: two frame buffers so filling
// continues while a completed frame waits on send; default is a single buffer.
module classifier_frame_packer
    import classifier_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input logic                      clk,
    input logic                      reset,
    classifier_frame_packer_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_width(N_SAMPLES);
    localparam logic [0:0]       ST_FILL  = FILL;
    localparam logic [0:0]       ST_SEND  = SEND;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

    logic             accept;
    logic             send_fire;
    logic             idx_last;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign accept    = bus.recv_val && bus.recv_rdy;
    assign send_fire = bus.send_val && bus.send_rdy;
    assign idx_last  = (idx_q == IDX_LAST);

    // Sample index: advance per accepted sample, wrap by compare so any N works.
    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
    end

    // Index register; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

`ifdef CLASSIFIER_FRAME_PACKER_PINGPONG_EN

    // Each buffer carries its own FILL/SEND flag; only one buffer fills at a time.
    logic [1:0]           buf_state_q;
    logic [1:0]           buf_state_d;
    logic                 fill_sel_q;
    logic                 fill_sel_d;
    logic                 send_sel_q;
    logic                 send_sel_d;
    logic                 both_full;
    logic [BIT_WIDTH-1:0] frame0 [N_SAMPLES-1:0];
    logic [BIT_WIDTH-1:0] frame1 [N_SAMPLES-1:0];

    assign both_full = (buf_state_q[0] == ST_SEND) && (buf_state_q[1] == ST_SEND);

    // Free the presented buffer on send and mark the filled one complete; the two
    // never target the same buffer, so a same-cycle send and final accept compose.
    always_comb begin
        buf_state_d = buf_state_q;
        fill_sel_d  = fill_sel_q;
        send_sel_d  = send_sel_q;
        if (send_fire) begin
            buf_state_d[send_sel_q] = ST_FILL;
            send_sel_d              = ~send_sel_q;
        end
        if (accept && idx_last) begin
            buf_state_d[fill_sel_q] = ST_SEND;
            fill_sel_d              = ~fill_sel_q;
        end
    end

    // Buffer flags and fill/send pointers; toggling pointers keeps fill order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_state_q <= {ST_FILL, ST_FILL};
            fill_sel_q  <= 1'b0;
            send_sel_q  <= 1'b0;
        end else begin
            buf_state_q <= buf_state_d;
            fill_sel_q  <= fill_sel_d;
            send_sel_q  <= send_sel_d;
        end
    end

    classifier_frame_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_buf0 (
        .clk   (clk),
        .reset (reset),
        .we    (accept && !fill_sel_q),
        .waddr (idx_q),
        .wdata (bus.recv_msg),
        .data  (frame0)
    );

    classifier_frame_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_buf1 (
        .clk   (clk),
        .reset (reset),
        .we    (accept && fill_sel_q),
        .waddr (idx_q),
        .wdata (bus.recv_msg),
        .data  (frame1)
    );

    assign bus.recv_rdy = reset && !both_full;
    assign bus.send_val = (buf_state_q[send_sel_q] == ST_SEND);

    // Present the oldest complete buffer.
    always_comb begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            bus.send_msg[k] = send_sel_q ? frame1[k] : frame0[k];
        end
    end

`else

    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic [BIT_WIDTH-1:0] frame [N_SAMPLES-1:0];

    // FILL until the last sample lands, then SEND until the classifier takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (accept && idx_last) state_d = ST_SEND;
            ST_SEND: if (bus.send_rdy)       state_d = ST_FILL;
            default:                         state_d = ST_FILL;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    classifier_frame_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (idx_q),
        .wdata (bus.recv_msg),
        .data  (frame)
    );

    assign bus.recv_rdy = reset && (state_q == ST_FILL);
    assign bus.send_val = (state_q == ST_SEND);

    // Frame output straight from the buffer; it cannot change while in SEND.
    always_comb begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            bus.send_msg[k] = frame[k];
        end
    end

`endif

endmodule
